// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the decode/operand pipeline:
//   op_state_e      - operand output register FSM encoding (EMPTY/FULL/STALL)
//   ZERO_REG        - architectural hard-wired zero register index
//   JAL_LINK_OFFSET - link value offset written into op_a for jump-and-link
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_STALL = 2'd2
    } op_state_e;

    localparam int unsigned ZERO_REG        = 32'd0;
    localparam int unsigned JAL_LINK_OFFSET = 32'd8;

endpackage

// File: rtl/fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
// Picks the value for one source operand: the youngest (lowest index) valid
// forwarding source whose destination matches addr, otherwise the register
// file data. The zero register never matches and always reads as zero.
// Ports:
//   addr      in  AW          source register address
//   rf_data   in  XLEN        register-file read data for addr
//   fwd_we    in  NFWD        forwarding source write enables
//   fwd_rd    in  NFWD*AW     forwarding destination addresses
//   fwd_data  in  NFWD*XLEN   forwarding data
//   fwd_pend  in  NFWD        forwarding source is a load with data not ready
//   data      out XLEN        selected operand value
//   pend      out 1           selected source is still pending
// -----------------------------------------------------------------------------
module fwd_select
    import cpu_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    parameter  int NFWD = 3,
    localparam int AW   = $clog2(NREG)
) (
    input  logic [AW-1:0]        addr,
    input  logic [XLEN-1:0]      rf_data,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [NFWD*AW-1:0]   fwd_rd,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic [NFWD-1:0]      fwd_pend,
    output logic [XLEN-1:0]      data,
    output logic                 pend
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [XLEN-1:0] scan_data_s;
    logic            scan_pend_s;

    // Priority scan: walk from oldest to youngest so the lowest matching index wins.
    always_comb begin
        scan_data_s = rf_data;
        scan_pend_s = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && (fwd_rd[i*AW +: AW] == addr)) begin
                scan_data_s = fwd_data[i*XLEN +: XLEN];
                scan_pend_s = fwd_pend[i];
            end else begin
                scan_data_s = scan_data_s;
                scan_pend_s = scan_pend_s;
            end
        end
    end

    // Zero register overrides any forwarding match and any register-file value.
    always_comb begin
        data = '0;
        pend = 1'b0;
        if (addr == ZERO_ADDR) begin
            data = '0;
            pend = 1'b0;
        end else begin
            data = scan_data_s;
            pend = scan_pend_s;
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// -----------------------------------------------------------------------------
// id_operand_stage
// Resolves the two source operands of the instruction in ID (forwarding,
// zero register, jump-and-link link value), detects load-use hazards and
// registers the operands towards EX behind a valid/ready handshake.
// Optional feature macro: ID_OPERAND_STALL_CNT_EN adds a saturating 32-bit
// stall-cycle counter on port stall_cnt.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid / in_ready   decoded-instruction handshake from IF/ID
//   rs, rt                source register addresses
//   is_jal, pc            jump-and-link flag and its pc
//   rf_a, rf_b            register-file read data for rs/rt
//   fwd_we/rd/data/pend   forwarding sources, index 0 youngest
//   flush                 kill the instruction in ID and the output register
//   out_valid / out_ready operand handshake to EX
//   op_a, op_b            registered operands
//   stall                 load-use stall this cycle
//   stall_cnt             (ID_OPERAND_STALL_CNT_EN only) stall cycle count
// -----------------------------------------------------------------------------
module id_operand_stage
    import cpu_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    parameter  int NFWD = 3,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AW-1:0]        rs,
    input  logic [AW-1:0]        rt,
    input  logic                 is_jal,
    input  logic [XLEN-1:0]      pc,
    input  logic [XLEN-1:0]      rf_a,
    input  logic [XLEN-1:0]      rf_b,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [NFWD*AW-1:0]   fwd_rd,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic [NFWD-1:0]      fwd_pend,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      op_a,
    output logic [XLEN-1:0]      op_b,
    output logic                 stall
`ifdef ID_OPERAND_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    op_state_e       state_r;
    op_state_e       state_next_s;
    logic [XLEN-1:0] src_a_s;
    logic [XLEN-1:0] src_b_s;
    logic            pend_a_s;
    logic            pend_b_s;
    logic [XLEN-1:0] cap_a_s;
    logic [XLEN-1:0] cap_b_s;
    logic            hazard_s;
    logic            stall_s;
    logic            in_ready_s;
    logic            capture_s;
    logic [XLEN-1:0] op_a_r;
    logic [XLEN-1:0] op_b_r;
    logic            out_valid_r;

    fwd_select #(.XLEN(XLEN), .NREG(NREG), .NFWD(NFWD)) u_sel_a (
        .addr     (rs),
        .rf_data  (rf_a),
        .fwd_we   (fwd_we),
        .fwd_rd   (fwd_rd),
        .fwd_data (fwd_data),
        .fwd_pend (fwd_pend),
        .data     (src_a_s),
        .pend     (pend_a_s)
    );

    fwd_select #(.XLEN(XLEN), .NREG(NREG), .NFWD(NFWD)) u_sel_b (
        .addr     (rt),
        .rf_data  (rf_b),
        .fwd_we   (fwd_we),
        .fwd_rd   (fwd_rd),
        .fwd_data (fwd_data),
        .fwd_pend (fwd_pend),
        .data     (src_b_s),
        .pend     (pend_b_s)
    );

    // Operand values to capture and hazard detection; jal needs no sources.
    always_comb begin
        cap_a_s  = src_a_s;
        cap_b_s  = src_b_s;
        hazard_s = 1'b0;
        if (is_jal) begin
            cap_a_s  = pc + XLEN'(JAL_LINK_OFFSET);
            cap_b_s  = '0;
            hazard_s = 1'b0;
        end else begin
            cap_a_s  = src_a_s;
            cap_b_s  = src_b_s;
            hazard_s = pend_a_s | pend_b_s;
        end
    end

    // A flushed or reset instruction is dead, so it never reports a stall.
    assign stall_s    = in_valid & hazard_s & ~flush & ~reset;
    assign in_ready_s = ((state_r != ST_FULL) | out_ready) & ~stall_s;
    assign capture_s  = in_valid & in_ready_s & ~flush;

    // Next-state logic; flush wins over every other transition.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_valid) begin
                        state_next_s = hazard_s ? ST_STALL : ST_FULL;
                    end else begin
                        state_next_s = ST_EMPTY;
                    end
                end
                ST_STALL: begin
                    if (!in_valid) begin
                        state_next_s = ST_EMPTY;
                    end else if (hazard_s) begin
                        state_next_s = ST_STALL;
                    end else begin
                        state_next_s = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        state_next_s = (in_valid && !hazard_s) ? ST_FULL : ST_EMPTY;
                    end else begin
                        state_next_s = ST_FULL;
                    end
                end
                default: begin
                    state_next_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Output register: valid tracks the FULL state, operands load on capture only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            op_a_r      <= '0;
            op_b_r      <= '0;
        end else begin
            out_valid_r <= (state_next_s == ST_FULL);
            if (capture_s) begin
                op_a_r <= cap_a_s;
                op_b_r <= cap_b_s;
            end else begin
                op_a_r <= op_a_r;
                op_b_r <= op_b_r;
            end
        end
    end

`ifdef ID_OPERAND_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of stall cycles; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

    assign in_ready  = in_ready_s;
    assign stall     = stall_s;
    assign out_valid = out_valid_r;
    assign op_a      = op_a_r;
    assign op_b      = op_b_r;

endmodule

// File: tb/tb_id_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_id_operand_stage
// Directed scenarios plus randomized traffic against a transaction-level
// reference model (operand lookup by priority search, output register as a
// valid flag with held values).
// -----------------------------------------------------------------------------
module tb_id_operand_stage;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NFWD = 3;
    localparam int AW   = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [AW-1:0]        rs;
    logic [AW-1:0]        rt;
    logic                 is_jal;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      rf_a;
    logic [XLEN-1:0]      rf_b;
    logic [NFWD-1:0]      fwd_we;
    logic [NFWD*AW-1:0]   fwd_rd;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic [NFWD-1:0]      fwd_pend;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      op_a;
    logic [XLEN-1:0]      op_b;
    logic                 stall;
`ifdef ID_OPERAND_STALL_CNT_EN
    logic [31:0]          stall_cnt;
`endif

    id_operand_stage #(.XLEN(XLEN), .NREG(NREG), .NFWD(NFWD)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs        (rs),
        .rt        (rt),
        .is_jal    (is_jal),
        .pc        (pc),
        .rf_a      (rf_a),
        .rf_b      (rf_b),
        .fwd_we    (fwd_we),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data),
        .fwd_pend  (fwd_pend),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .stall     (stall)
`ifdef ID_OPERAND_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic        m_valid;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [31:0] m_cnt;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference operand lookup: first enabled source (youngest first) writing addr.
    task automatic ref_sel(input logic [AW-1:0] addr, input logic [31:0] rf,
                           output logic [31:0] val, output logic pnd);
        bit found = 1'b0;
        val = rf;
        pnd = 1'b0;
        if (addr == 5'd0) begin
            val = 32'd0;
        end else begin
            for (int i = 0; i < NFWD; i++) begin
                if (!found && fwd_we[i] && fwd_rd[i*AW +: AW] == addr) begin
                    found = 1'b1;
                    val   = fwd_data[i*XLEN +: XLEN];
                    pnd   = fwd_pend[i];
                end
            end
        end
    endtask

    // One clock: check handshake/stall from current inputs, advance model, check outputs.
    task automatic cyc();
        logic [31:0] ea, eb;
        logic        pa, pb, hz, e_stall, e_ready, cap;
        #1;
        pa = 1'b0;
        pb = 1'b0;
        if (is_jal) begin
            ea = pc + 32'd8;
            eb = 32'd0;
            hz = 1'b0;
        end else begin
            ref_sel(rs, rf_a, ea, pa);
            ref_sel(rt, rf_b, eb, pb);
            hz = pa | pb;
        end
        e_stall = in_valid && hz && !flush;
        e_ready = (!m_valid || out_ready) && !e_stall;
        check_val("stall", {63'd0, stall}, {63'd0, e_stall});
        check_val("in_ready", {63'd0, in_ready}, {63'd0, e_ready});
        cap = in_valid && e_ready && !flush;
        @(posedge clk);
        if (e_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (flush) begin
            m_valid = 1'b0;
        end else if (cap) begin
            m_valid = 1'b1;
            m_a     = ea;
            m_b     = eb;
        end else if (m_valid && !out_ready) begin
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        #1;
        check_val("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        check_val("op_a", {32'd0, op_a}, {32'd0, m_a});
        check_val("op_b", {32'd0, op_b}, {32'd0, m_b});
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        is_jal    = 1'b0;
        fwd_we    = '0;
        fwd_pend  = '0;
        fwd_rd    = '0;
        fwd_data  = '0;
        rs        = '0;
        rt        = '0;
        pc        = '0;
        rf_a      = '0;
        rf_b      = '0;
    endtask

    initial begin
        idle();
        reset   = 1'b1;
        m_valid = 1'b0;
        m_a     = 32'd0;
        m_b     = 32'd0;
        m_cnt   = 32'd0;
        // Pending-hazard instruction presented during reset must not stall.
        in_valid = 1'b1;
        rs       = 5'd4;
        fwd_we   = 3'b001;
        fwd_rd   = {10'd0, 5'd4};
        fwd_pend = 3'b001;
        #12;
        check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst_op_a", {32'd0, op_a}, 64'd0);
        check_val("rst_op_b", {32'd0, op_b}, 64'd0);
        check_val("rst_stall", {63'd0, stall}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();

        // Youngest matching forwarding source wins.
        in_valid = 1'b1;
        rs       = 5'd5;
        rt       = 5'd3;
        rf_a     = 32'h1234_5678;
        rf_b     = 32'h0000_0033;
        fwd_we   = 3'b011;
        fwd_rd   = {5'd0, 5'd5, 5'd5};
        fwd_data = {32'h0, 32'h22, 32'h11};
        cyc();
        check_val("fwd_youngest_a", {32'd0, op_a}, 64'h11);
        check_val("fwd_none_b", {32'd0, op_b}, 64'h33);

        // Zero register ignores forwarding and register-file data.
        rs       = 5'd1;
        rt       = 5'd0;
        rf_b     = 32'h7;
        fwd_we   = 3'b001;
        fwd_rd   = {10'd0, 5'd0};
        fwd_data = {64'd0, 32'hFF};
        cyc();
        check_val("zero_reg_b", {32'd0, op_b}, 64'd0);

        // Jump-and-link ignores pending sources.
        is_jal   = 1'b1;
        pc       = 32'h0040_0010;
        fwd_we   = 3'b111;
        fwd_rd   = {5'd1, 5'd1, 5'd1};
        fwd_pend = 3'b111;
        cyc();
        check_val("jal_a", {32'd0, op_a}, 64'h0040_0018);
        check_val("jal_b", {32'd0, op_b}, 64'd0);
        idle();
        cyc();

        // Load-use stall for two cycles, then forwarded data captured.
        in_valid = 1'b1;
        rs       = 5'd8;
        rt       = 5'd0;
        fwd_we   = 3'b001;
        fwd_rd   = {10'd0, 5'd8};
        fwd_pend = 3'b001;
        cyc();
        check_val("lu_stall1", {63'd0, stall}, 64'd1);
        check_val("lu_ready1", {63'd0, in_ready}, 64'd0);
        cyc();
        check_val("lu_stall2", {63'd0, stall}, 64'd1);
        fwd_pend = 3'b000;
        fwd_data = {64'd0, 32'h5A};
        cyc();
        check_val("lu_op_a", {32'd0, op_a}, 64'h5A);
        check_val("lu_valid", {63'd0, out_valid}, 64'd1);
`ifdef ID_OPERAND_STALL_CNT_EN
        check_val("lu_stall_cnt", {32'd0, stall_cnt}, 64'd2);
`endif

        // Back-pressure holds the output register; flush clears valid.
        idle();
        in_valid = 1'b1;
        rs       = 5'd2;
        rt       = 5'd6;
        rf_a     = 32'hAAAA;
        rf_b     = 32'hBBBB;
        cyc();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rf_a = 32'hC000 + 32'(k);
            rf_b = 32'hD000 + 32'(k);
            cyc();
            check_val("hold_a", {32'd0, op_a}, 64'hAAAA);
            check_val("hold_b", {32'd0, op_b}, 64'hBBBB);
            check_val("hold_ready", {63'd0, in_ready}, 64'd0);
        end
        flush = 1'b1;
        cyc();
        check_val("flush_valid", {63'd0, out_valid}, 64'd0);
        idle();
        cyc();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            is_jal    = ($urandom_range(0, 7) == 0);
            rs        = 5'($urandom_range(0, 7));
            rt        = 5'($urandom_range(0, 7));
            pc        = $urandom;
            rf_a      = $urandom;
            rf_b      = $urandom;
            fwd_we    = 3'($urandom);
            fwd_pend  = 3'($urandom & $urandom);
            for (int i = 0; i < NFWD; i++) begin
                fwd_rd[i*AW +: AW]     = 5'($urandom_range(0, 7));
                fwd_data[i*XLEN +: XLEN] = $urandom;
            end
            cyc();
        end
`ifdef ID_OPERAND_STALL_CNT_EN
        check_val("rand_stall_cnt", {32'd0, stall_cnt}, {32'd0, m_cnt});
`endif

        // Reset while FULL discards the held instruction.
        idle();
        in_valid  = 1'b1;
        rs        = 5'd3;
        rf_a      = 32'h9999;
        out_ready = 1'b0;
        cyc();
        #2;
        reset = 1'b1;
        #1;
        check_val("midrst_valid", {63'd0, out_valid}, 64'd0);
        check_val("midrst_op_a", {32'd0, op_a}, 64'd0);
        check_val("midrst_stall", {63'd0, stall}, 64'd0);
        m_valid = 1'b0;
        m_a     = 32'd0;
        m_b     = 32'd0;
        m_cnt   = 32'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
`ifdef ID_OPERAND_STALL_CNT_EN
        check_val("rst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
`endif
        for (int k = 0; k < 3; k++) begin
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
